// File: rtl/cts_cnt_pipe_if.sv
// Bundle of count controls into, and delayed count results out of, cts_cnt_pipe.
// Purely a wiring container; all timing lives in the counter block.
// master drives controls and receives results; slave is the counter side.
interface cts_cnt_pipe_if #(
    parameter int NCH   = 2,
    parameter int WIDTH = 4
);
    logic [NCH-1:0]       on;
    logic [NCH-1:0]       up;
    logic [NCH-1:0]       load;
    logic [NCH*WIDTH-1:0] load_val;
    logic [NCH*WIDTH-1:0] cnt;
    logic [NCH-1:0]       tc;
    logic                 cnt_vld;

    modport master (
        output on, up, load, load_val,
        input  cnt, tc, cnt_vld
    );

    modport slave (
        input  on, up, load, load_val,
        output cnt, tc, cnt_vld
    );
endinterface

// File: rtl/cts_cnt_pipe.sv
// Multi-channel enabled up/down counter feeding a STAGES-deep registered delay line (build option CTS_CNT_SAT_EN: saturate instead of wrap).
// Latency: input sampled at edge k reaches c after edge k and cnt/tc after edge k+STAGES.
// No backpressure: the core updates and the delay line shifts on every edge; there is no stall.
module cts_cnt_pipe #(
    parameter int NCH    = 2,
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    cts_cnt_pipe_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_V = '1;
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

    // Core counter and terminal-event register (stage "0" of the pipeline).
    logic [WIDTH-1:0] r_c [NCH];
    logic [NCH-1:0]   r_te;

    // Delay line: index 0 is d[1], index STAGES-1 drives cnt.
    logic [WIDTH-1:0] r_d [NCH][STAGES];
    logic [NCH-1:0]   r_tcl [STAGES];

    // Valid shift register: bit STAGES rises STAGES+1 edges after reset release.
    logic [STAGES:0]  r_vld;

    logic [WIDTH-1:0] w_c_nxt [NCH];
    logic [NCH-1:0]   w_te_nxt;

    // Next-state for each core: load beats count; terminal event flags a limit crossing.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_c_nxt[i]  = r_c[i];
            w_te_nxt[i] = 1'b0;
            if (bus.load[i]) begin
                w_c_nxt[i] = bus.load_val[i*WIDTH +: WIDTH];
            end else if (bus.on[i]) begin
                if (bus.up[i]) begin
                    if (r_c[i] == MAX_V) begin
                        w_te_nxt[i] = 1'b1;
`ifdef CTS_CNT_SAT_EN
                        w_c_nxt[i]  = MAX_V;
`else
                        w_c_nxt[i]  = ZERO_V;
`endif
                    end else begin
                        w_c_nxt[i] = r_c[i] + ONE_V;
                    end
                end else begin
                    if (r_c[i] == ZERO_V) begin
                        w_te_nxt[i] = 1'b1;
`ifdef CTS_CNT_SAT_EN
                        w_c_nxt[i]  = ZERO_V;
`else
                        w_c_nxt[i]  = MAX_V;
`endif
                    end else begin
                        w_c_nxt[i] = r_c[i] - ONE_V;
                    end
                end
            end
        end
    end

    // Core counters and their terminal-event flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_c[i] <= '0;
            end
            r_te <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_c[i] <= w_c_nxt[i];
            end
            r_te <= w_te_nxt;
        end
    end

    // Count and tc delay lines shift unconditionally so tc stays aligned with its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                for (int s = 0; s < STAGES; s++) begin
                    r_d[i][s] <= '0;
                end
            end
            for (int s = 0; s < STAGES; s++) begin
                r_tcl[s] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_d[i][0] <= r_c[i];
                for (int s = 1; s < STAGES; s++) begin
                    r_d[i][s] <= r_d[i][s-1];
                end
            end
            r_tcl[0] <= r_te;
            for (int s = 1; s < STAGES; s++) begin
                r_tcl[s] <= r_tcl[s-1];
            end
        end
    end

    // Valid line fills with ones from reset release and then stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[STAGES-1:0], 1'b1};
        end
    end

    // Outputs come straight from the last delay stage.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            bus.cnt[i*WIDTH +: WIDTH] = r_d[i][STAGES-1];
        end
        bus.tc      = r_tcl[STAGES-1];
        bus.cnt_vld = r_vld[STAGES];
    end

endmodule
